// File: rtl/peripheral_mpram_biu_master.sv
// Burst master for the MPRAM TL slave: splits a command into beats, issues them on biu_*,
// and returns one response per beat through a small first-word-fall-through FIFO.
module peripheral_mpram_biu_master #(
  parameter int PLEN      = 64,
  parameter int XLEN      = 64,
  parameter int RSP_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [PLEN-1:0] req_addr_i,
  input  logic            req_we_i,
  input  logic [3:0]      req_len_i,
  input  logic [2:0]      req_size_i,
  input  logic [2:0]      req_prot_i,
  input  logic            req_lock_i,

  input  logic            wdata_valid_i,
  output logic            wdata_ready_o,
  input  logic [XLEN-1:0] wdata_i,

  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_err_o,
  output logic            rsp_last_o,

  output logic            biu_stb_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_d_ack_i,
  output logic [PLEN-1:0] biu_adri_o,
  output logic [2:0]      biu_size_o,
  output logic [2:0]      biu_type_o,
  output logic [2:0]      biu_prot_o,
  output logic            biu_lock_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic [XLEN-1:0] biu_q_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i,

  output logic            busy_o,
  output logic [1:0]      dbg_state_o
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // req/wdata/rsp follow that rule, and a biu beat is taken when biu_stb_o & biu_stb_ack_i.

  localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
    logic            last;
  } rsp_t;

  state_t          state_q, state_d;
  logic [PLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [3:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [2:0]      prot_q, prot_d;
  logic            lock_q, lock_d;
  logic [4:0]      issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic            abort_q, abort_d;

  rsp_t            mem_q [RSP_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            stb;
  logic            accept;
  logic            comp;
  logic            credit_ok;
  logic            push;
  logic            pop;
  rsp_t            push_ent;
  rsp_t            head;
  logic            unused_d_ack;

  assign unused_d_ack = biu_d_ack_i;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    len_d       = len_q;
    size_d      = size_q;
    prot_d      = prot_q;
    lock_d      = lock_q;
    issue_cnt_d = issue_cnt_q;
    outst_d     = outst_q;
    abort_d     = abort_q;
    stb         = 1'b0;
    push_ent    = '0;

    // Outstanding beats plus queued responses may never exceed the FIFO size.
    credit_ok = ({1'b0, outst_q} + {1'b0, count_q}) < (CW+1)'(RSP_DEPTH);
    comp      = (biu_ack_i | biu_err_i) && (outst_q != '0);

    if (state_q == ISSUE) begin
      stb = (issue_cnt_q != 5'd0) && !abort_q && !biu_err_i && credit_ok &&
            (!we_q || wdata_valid_i);
    end
    accept = stb && biu_stb_ack_i;

    if (accept) begin
      addr_d      = addr_q + (PLEN'(1) << size_q);
      issue_cnt_d = issue_cnt_q - 5'd1;
    end
    if (comp && biu_err_i) begin
      abort_d = 1'b1;
    end
    outst_d = outst_q + CW'(accept) - CW'(comp);

    push          = comp;
    push_ent.data = we_q ? '0 : biu_q_i;
    push_ent.err  = biu_err_i;
    push_ent.last = (outst_d == '0) && ((issue_cnt_d == 5'd0) || abort_d);

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d      = req_addr_i;
          we_d        = req_we_i;
          len_d       = req_len_i;
          size_d      = req_size_i;
          prot_d      = req_prot_i;
          lock_d      = req_lock_i;
          issue_cnt_d = {1'b0, req_len_i} + 5'd1;
          outst_d     = '0;
          abort_d     = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if ((issue_cnt_q == 5'd0) || abort_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outst_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    pop      = (count_q != '0) && rsp_ready_i;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      len_q       <= 4'd0;
      size_q      <= 3'd0;
      prot_q      <= 3'd0;
      lock_q      <= 1'b0;
      issue_cnt_q <= 5'd0;
      outst_q     <= '0;
      abort_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      len_q       <= len_d;
      size_q      <= size_d;
      prot_q      <= prot_d;
      lock_q      <= lock_d;
      issue_cnt_q <= issue_cnt_d;
      outst_q     <= outst_d;
      abort_q     <= abort_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= push_ent;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign dbg_state_o   = state_q;
  assign biu_stb_o     = stb;
  assign biu_adri_o    = addr_q;
  assign biu_size_o    = size_q;
  assign biu_prot_o    = prot_q;
  assign biu_lock_o    = lock_q;
  assign biu_we_o      = we_q;
  assign biu_type_o    = (len_q == 4'd0) ? 3'b000 : 3'b001;
  assign biu_d_o       = ((state_q == ISSUE) && we_q) ? wdata_i : '0;
  assign wdata_ready_o = accept && we_q;
  assign rsp_valid_o   = (count_q != '0);
  assign rsp_data_o    = rsp_valid_o ? head.data : '0;
  assign rsp_err_o     = rsp_valid_o && head.err;
  assign rsp_last_o    = rsp_valid_o && head.last;

endmodule
